// File: rtl/vga_timing_gen.sv
// Raster timing generator feeding the gfx compositor and the video output stage.
// Every output is registered from the same next-count values, so x, y, syncs,
// data-enable and strobes always describe one and the same raster position.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int FRAME_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_pix_en,
    output logic [15:0]        o_x,
    output logic [15:0]        o_y,
    output logic               o_h_sync,
    output logic               o_v_sync,
    output logic               o_de,
    output logic               o_line_start,
    output logic               o_frame_start,
    output logic [FRAME_W-1:0] o_frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT_END  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT_END  = 16'(V_ACTIVE);
    localparam logic [15:0] H_SYNC_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] H_SYNC_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] V_SYNC_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] V_SYNC_END = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic               r_running;
    logic [15:0]        r_x;
    logic [15:0]        r_y;
    logic               r_h_sync;
    logic               r_v_sync;
    logic               r_de;
    logic               r_line_start;
    logic               r_frame_start;
    logic [FRAME_W-1:0] r_frame_count;

    logic        w_x_last;
    logic        w_y_last;
    logic        w_wrap;
    logic [15:0] w_x_cnt;
    logic [15:0] w_y_cnt;
    logic        w_de;
    logic        w_hs_act;
    logic        w_vs_act;

    // Next raster position and its decode; before start-up the next position is (0,0)
    always_comb begin
        w_x_last = (r_x == H_LAST);
        w_y_last = (r_y == V_LAST);
        w_wrap   = w_x_last && w_y_last;
        w_x_cnt  = 16'd0;
        w_y_cnt  = 16'd0;
        if (r_running) begin
            w_x_cnt = w_x_last ? 16'd0 : (r_x + 16'd1);
            if (w_x_last) begin
                w_y_cnt = w_y_last ? 16'd0 : (r_y + 16'd1);
            end else begin
                w_y_cnt = r_y;
            end
        end
        w_de     = (w_x_cnt < H_ACT_END) && (w_y_cnt < V_ACT_END);
        w_hs_act = (w_x_cnt >= H_SYNC_BEG) && (w_x_cnt < H_SYNC_END);
        w_vs_act = (w_y_cnt >= V_SYNC_BEG) && (w_y_cnt < V_SYNC_END);
    end

    // Raster registers: advance on pixel enables, strobes self-clear every clock
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_running     <= 1'b0;
            r_x           <= 16'd0;
            r_y           <= 16'd0;
            r_h_sync      <= ~SYNC_POL;
            r_v_sync      <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (i_pix_en) begin
                r_running     <= 1'b1;
                r_x           <= w_x_cnt;
                r_y           <= w_y_cnt;
                r_de          <= w_de;
                r_h_sync      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
                r_v_sync      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
                r_line_start  <= (w_x_cnt == 16'd0);
                r_frame_start <= (w_x_cnt == 16'd0) && (w_y_cnt == 16'd0);
                // the start-up (0,0) is not a completed frame
                if (r_running && w_wrap) begin
                    r_frame_count <= r_frame_count + FRAME_W'(1);
                end
            end
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_h_sync      = r_h_sync;
    assign o_v_sync      = r_v_sync;
    assign o_de          = r_de;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;
    assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: hand-written vector tables for reset/start-up and
// reset mid-frame, plus a position-count reference for longer runs.
module tb_vga_timing_gen;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rst2;
    logic        rst3;

    logic [15:0] x, y;
    logic        hs, vs, de, ls, fs;
    logic [15:0] fc;

    logic [15:0] x2, y2;
    logic        hs2, vs2, de2, ls2, fs2;
    logic [1:0]  fc2;

    logic [15:0] x3, y3;
    logic        hs3, vs3, de3, ls3, fs3;
    logic [1:0]  fc3;

    int n_cmp = 0;
    int n_mis = 0;

    // small raster: H_TOTAL=14, V_TOTAL=8, 112 clocks per frame
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .FRAME_W(16)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_pix_en(en),
        .o_x(x), .o_y(y), .o_h_sync(hs), .o_v_sync(vs), .o_de(de),
        .o_line_start(ls), .o_frame_start(fs), .o_frame_count(fc)
    );

    // same small raster with a 2-bit frame counter
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .FRAME_W(2)
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst2), .i_pix_en(en),
        .o_x(x2), .o_y(y2), .o_h_sync(hs2), .o_v_sync(vs2), .o_de(de2),
        .o_line_start(ls2), .o_frame_start(fs2), .o_frame_count(fc2)
    );

    // default 640x480 timing
    vga_timing_gen #(.FRAME_W(2)) u_dut3 (
        .i_clk(clk), .i_rst(rst3), .i_pix_en(en),
        .o_x(x3), .o_y(y3), .o_h_sync(hs3), .o_v_sync(vs3), .o_de(de3),
        .o_line_start(ls3), .o_frame_start(fs3), .o_frame_count(fc3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit en;
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit ls;
        bit fs;
        int fc;
    } vec_t;

    vec_t tbl[8];

    // reference: running flag and number of advances since start-up
    bit m_run = 1'b0;
    int m_n   = 0;
    bit m_adv = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        if (r) begin
            m_run = 1'b0;
            m_n   = 0;
            m_adv = 1'b0;
        end else if (e) begin
            if (!m_run) begin
                m_run = 1'b1;
                m_n   = 0;
            end else begin
                m_n++;
            end
            m_adv = 1'b1;
        end else begin
            m_adv = 1'b0;
        end
    endtask

    task automatic check_model();
        int p, ex, ey;
        if (!m_run) begin
            chk("rst_x", x, 0);   chk("rst_y", y, 0);
            chk("rst_hs", hs, 1); chk("rst_vs", vs, 1);
            chk("rst_de", de, 0); chk("rst_ls", ls, 0);
            chk("rst_fs", fs, 0); chk("rst_fc", fc, 0);
        end else begin
            p  = m_n % 112;
            ex = p % 14;
            ey = p / 14;
            chk("x", x, ex);
            chk("y", y, ey);
            chk("de", de, (ex < 8 && ey < 4) ? 1 : 0);
            chk("h_sync", hs, (ex >= 10 && ex < 13) ? 0 : 1);
            chk("v_sync", vs, (ey >= 5 && ey < 7) ? 0 : 1);
            chk("line_start", ls, (m_adv && ex == 0) ? 1 : 0);
            chk("frame_start", fs, (m_adv && p == 0) ? 1 : 0);
            chk("frame_count", fc, m_n / 112);
        end
    endtask

    task automatic apply_vec(input int i);
        step(tbl[i].rst, tbl[i].en);
        chk($sformatf("v%0d_x", i), x, tbl[i].x);
        chk($sformatf("v%0d_y", i), y, tbl[i].y);
        chk($sformatf("v%0d_hs", i), hs, tbl[i].hs);
        chk($sformatf("v%0d_vs", i), vs, tbl[i].vs);
        chk($sformatf("v%0d_de", i), de, tbl[i].de);
        chk($sformatf("v%0d_ls", i), ls, tbl[i].ls);
        chk($sformatf("v%0d_fs", i), fs, tbl[i].fs);
        chk($sformatf("v%0d_fc", i), fc, tbl[i].fc);
    endtask

    initial begin
        int cnt_vs, cnt_hs, cnt_de, cnt_fs, cnt_x0, cnt_ls, n_fs2, guard;
        int exp_fc2[6];
        int ex3, ey3;

        //               rst en  x  y hs vs de ls fs fc
        tbl[0] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[1] = '{1'b1, 1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[2] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[3] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[4] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        tbl[5] = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        tbl[6] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        tbl[7] = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};

        exp_fc2 = '{0, 1, 2, 3, 0, 1};

        rst  = 1'b1;
        en   = 1'b0;
        rst2 = 1'b1;
        rst3 = 1'b1;

        // reset held 3 clocks, release, start-up, first advance
        for (int i = 0; i <= 4; i++) apply_vec(i);

        // one line, then two full frames
        cnt_vs = 0; cnt_hs = 0; cnt_de = 0; cnt_fs = 0;
        while (m_n < 224) begin
            step(1'b0, 1'b1);
            check_model();
            if (m_n >= 112 && m_n <= 223) begin
                if (vs == 1'b0) cnt_vs++;
                if (hs == 1'b0) cnt_hs++;
                if (de == 1'b1) cnt_de++;
            end
            if (fs) cnt_fs++;
        end
        chk("vsync_clocks_per_frame", cnt_vs, 28);
        chk("hsync_clocks_per_frame", cnt_hs, 24);
        chk("de_clocks_per_frame", cnt_de, 32);
        chk("frame_start_pulses", cnt_fs, 2);
        chk("frame_count_after_2", fc, 2);

        // walk to (5,3) of the third frame and reset there for one clock
        guard = 0;
        while (m_n % 112 != 47 && guard < 200) begin
            step(1'b0, 1'b1);
            check_model();
            guard++;
        end
        chk("pre_reset_x", x, 5);
        chk("pre_reset_y", y, 3);
        for (int i = 5; i <= 7; i++) apply_vec(i);

        // pixel enable pattern 1,0,0,1 from a fresh reset
        step(1'b1, 1'b1);
        check_model();
        cnt_x0 = 0; cnt_ls = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, (i % 4 == 0 || i % 4 == 3) ? 1'b1 : 1'b0);
            check_model();
            if (x == 16'd0 && y == 16'd1) begin
                cnt_x0++;
                if (ls) cnt_ls++;
            end
        end
        chk("x0_hold_clocks", cnt_x0, 3);
        chk("line_start_at_wrap", cnt_ls, 1);

        // 2-bit frame counter over 5 frames; main instance parked in reset
        rst2  = 1'b0;
        n_fs2 = 0;
        for (int i = 0; i < 570; i++) begin
            step(1'b1, 1'b1);
            if (fs2) begin
                if (n_fs2 < 6) chk($sformatf("fc2_pulse%0d", n_fs2), fc2, exp_fc2[n_fs2]);
                n_fs2++;
            end
        end
        check_model();
        chk("fc2_pulse_count", n_fs2, 6);
        rst2 = 1'b1;

        // default 800x525 timing over two lines
        rst3 = 1'b0;
        for (int n = 0; n < 1700; n++) begin
            step(1'b1, 1'b1);
            ex3 = n % 800;
            ey3 = n / 800;
            chk("def_x", x3, ex3);
            chk("def_y", y3, ey3);
            chk("def_de", de3, (ex3 < 640) ? 1 : 0);
            chk("def_h_sync", hs3, (ex3 >= 656 && ex3 < 752) ? 0 : 1);
            chk("def_v_sync", vs3, 1);
            chk("def_line_start", ls3, (ex3 == 0) ? 1 : 0);
        end
        chk("def_frame_count", fc3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that sits directly upstream of the gfx compositor.
- Produces the pixel coordinates (x, y) and the v_sync that drive the compositor and its sprites, plus h_sync, data-enable and frame/line strobes for the video output stage.
- All outputs are registered and mutually aligned: every output in a given cycle describes the same raster position.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high), applies to both syncs
- FRAME_W, 16, width of the frame counter

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_pix_en  in  1  pixel-rate enable; the raster advances one pixel on each i_clk edge where i_pix_en=1
- o_x  out  16  horizontal position, 0..H_TOTAL-1 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP)
- o_y  out  16  vertical position, 0..V_TOTAL-1 (V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP)
- o_h_sync  out  1  horizontal sync, at SYNC_POL level when asserted
- o_v_sync  out  1  vertical sync, at SYNC_POL level when asserted
- o_de  out  1  data enable, high in the active region
- o_line_start  out  1  one-clock pulse when o_x becomes 0
- o_frame_start  out  1  one-clock pulse when (o_x,o_y) becomes (0,0)
- o_frame_count  out  FRAME_W  completed-frame counter

Behaviour:
- Reset: i_clk and i_rst form the single clock domain; reset is synchronous and active-high.
- Reset values, held while i_rst=1: o_x=0, o_y=0, o_de=0, o_line_start=0, o_frame_start=0, o_frame_count=0, o_h_sync=o_v_sync=~SYNC_POL.
- Start-up: an internal "running" flag clears on reset. On the first edge with i_rst=0 and i_pix_en=1, the flag sets and the outputs present (0,0) with o_de=1, o_line_start=1, o_frame_start=1. Counters do not advance on that edge.
- Advance: on each later edge with i_pix_en=1, o_x increments.
  - o_x = H_TOTAL-1 wraps to 0 and o_y increments.
  - o_y = V_TOTAL-1 together with o_x = H_TOTAL-1 wraps both to 0.
- Hold: edges with i_pix_en=0 hold o_x, o_y, syncs, o_de and o_frame_count.
- Strobes: o_line_start and o_frame_start drop to 0 after one clock even when i_pix_en stays low.
- Decode, computed from the next-count values so it is registered in the same cycle as the coordinates:
  - o_de = (x < H_ACTIVE) && (y < V_ACTIVE)
  - h_sync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC
  - v_sync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, for the whole line including blanking pixels
- o_frame_count: increments modulo 2^FRAME_W on every wrap to (0,0), in the same cycle o_frame_start pulses. The start-up (0,0) does not count.
- Reset mid-frame: on the next edge, all outputs return to their reset values regardless of i_pix_en. Start-up then repeats.
- Widths: the counters are 16 bits and H_TOTAL, V_TOTAL <= 65535. No other arithmetic overflow is possible.

Test Plan:
Small parameters for benches 1-5: H 8/2/3/1 (H_TOTAL=14), V 4/1/2/1 (V_TOTAL=8), SYNC_POL=0, i_pix_en=1.
1. Reset held 3 clocks, then released -> during reset o_de=0, o_h_sync=o_v_sync=1, o_frame_count=0. First edge after release gives (0,0), o_de=1, o_frame_start=1, o_line_start=1. Next edge gives x=1 with both strobes 0.
2. Run one line -> o_de=1 for x=0..7 and 0 for x=8..13. o_h_sync=0 exactly for x=10..12. x=13 is followed by x=0, y=1 with o_line_start=1.
3. Run 2 frames -> o_v_sync=0 exactly while y=5..6 (28 clocks per frame). o_frame_start pulses every 112 clocks. o_frame_count reads 1, then 2.
4. i_pix_en toggled 1,0,0,1 repeating -> x advances only on enabled edges. o_line_start at a wrap is high for exactly 1 clock while x=0 persists for 3 clocks.
5. Assert i_rst at x=5, y=3 for 1 clock -> the next cycle shows reset values. Start-up (0,0) follows. o_frame_count=0.
6. Default parameters with FRAME_W=2, run 5 frames -> V_TOTAL=525 and H_TOTAL=800 (420000 clocks per frame). o_frame_count sequence is 1,2,3,0,1.
